sync_fifo_mem: RTL and testbench
================================

// Module: sync_fifo_mem
// PURPOSE
//  Parametrised single-clock FIFO built on a simple dual-port register array with
//  registered (1-cycle) read data. Generalises the plain addressed memory used in
//  the dot-product datapath: internal pointer management, occupancy count,
//  programmable almost-full/almost-empty flags, read-valid strobe and sticky error flags.
//  Sits between operand producers and the dot-product FSM as the elastic operand buffer.
// PARAMETERS
//  DATA_WIDTH      32  width of each stored word
//  ADDR_WIDTH      5   pointer width; DEPTH = 2**ADDR_WIDTH entries (default 32)
//  ALMOST_FULL_TH  28  almost_full asserted when count >= ALMOST_FULL_TH
//  ALMOST_EMPTY_TH 4   almost_empty asserted when count <= ALMOST_EMPTY_TH
// PORTS
//  clk           in   1             single clock, all logic on rising edge
//  rst           in   1             synchronous, active-high reset
//  wr_en         in   1             write request
//  wr_data       in   DATA_WIDTH    write data
//  rd_en         in   1             read request
//  rd_data       out  DATA_WIDTH    registered read data
//  rd_valid      out  1             rd_data carries a newly popped word this cycle
//  full          out  1             count == DEPTH
//  empty         out  1             count == 0
//  almost_full   out  1             count >= ALMOST_FULL_TH
//  almost_empty  out  1             count <= ALMOST_EMPTY_TH
//  count         out  ADDR_WIDTH+1  current occupancy, 0..DEPTH
//  overflow      out  1             sticky: write attempted while full
//  underflow     out  1             sticky: read attempted while empty
// BEHAVIOUR
//  - Reset (rst=1 at posedge): wr_ptr=rd_ptr=0, count=0, rd_data=0, rd_valid=0,
//    overflow=underflow=0; hence empty=1, full=0, almost_empty=1, almost_full=0
//    (for TH>0). Array contents are NOT cleared. Reset dominates all requests.
//  - wr_acc = wr_en & ~full; rd_acc = rd_en & ~empty; both evaluated on flags
//    as they stand before the edge.
//  - wr_acc: mem[wr_ptr] <= wr_data; wr_ptr <= wr_ptr+1 (wraps DEPTH-1 -> 0).
//  - rd_acc: rd_data <= mem[rd_ptr]; rd_ptr <= rd_ptr+1 (wraps); rd_valid <= 1
//    next cycle. No rd_acc: rd_valid <= 0, rd_data holds its last value.
//  - Read latency: exactly 1 cycle from accepted rd_en to rd_valid/rd_data.
//  - count: +1 on wr_acc only, -1 on rd_acc only, unchanged on both or neither.
//  - Flags are combinational decodes of registered count (no extra latency).
//  - Full + wr_en + rd_en: read accepted, write rejected, overflow set; count DEPTH-1.
//  - Empty + wr_en + rd_en: write accepted, read rejected (no fall-through),
//    underflow set; count 1; rd_valid 0 next cycle.
//  - Otherwise simultaneous wr_acc and rd_acc both proceed; pointers never
//    collide on the same entry because count is neither 0 nor DEPTH.
//  - overflow/underflow: set on rejected request, held until rst.
//  - Reset mid-stream drops all stored data; first write after reset goes to entry 0.
//  - Flags/count are never written from rd_en/wr_en combinationally; outputs are
//    glitch-free registered values or decodes of registers.
// TESTING
//  1 rst, write 0xA0..0xA4 (5 words), then 5 reads -> rd_valid 1 cycle after
//    each rd_en, rd_data 0xA0..0xA4 in order, count 5->0, empty=1 at end.
//  2 write 32 words -> full=1, count=32, almost_full from count 28; 33rd write ->
//    overflow=1, count stays 32; read-back returns first 32 words only.
//  3 empty FIFO, rd_en=1 -> underflow=1, rd_valid=0, rd_data unchanged, count 0.
//  4 count=10, wr_en=rd_en=1 for 40 cycles with incrementing data -> count stays 10,
//    pointers wrap, output sequence continuous and in order.
//  5 full FIFO, wr_en=rd_en=1 one cycle -> count 31, overflow=1, oldest word out;
//    empty FIFO, wr_en=rd_en=1 -> count 1, underflow=1, rd_valid=0.
//  6 count=12, assert rst one cycle mid-stream -> count 0, empty=1, rd_valid=0,
//    rd_data=0, flags cleared; write 0x55 then read -> rd_data 0x55.

Source files
------------

// File: rtl/sync_fifo_mem_if.sv
// Handshake/status bundle for sync_fifo_mem: producer/consumer side is master,
// the FIFO itself is slave.
interface sync_fifo_mem_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [ADDR_WIDTH:0]   count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output wr_en, wr_data, rd_en,
    input  rd_data, rd_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

  modport slave (
    input  wr_en, wr_data, rd_en,
    output rd_data, rd_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_mem.sv
// Single-clock FIFO on a dual-port register array with 1-cycle registered read,
// occupancy count, programmable almost flags and sticky over/underflow flags.
module sync_fifo_mem #(
  parameter int DATA_WIDTH      = 32,
  parameter int ADDR_WIDTH      = 5,
  parameter int ALMOST_FULL_TH  = 28,
  parameter int ALMOST_EMPTY_TH = 4
) (
  input logic              clk,
  input logic              rst,
  sync_fifo_mem_if.slave   bus
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int CW    = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(ALMOST_FULL_TH);
  localparam logic [CW-1:0] AE_C    = CW'(ALMOST_EMPTY_TH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0]         count;
  logic                  wr_acc, rd_acc;
  // vld_pipe[0] is the accepted read this cycle, vld_pipe[1] the strobe with the data
  logic [1:0]            vld_pipe;

  assign bus.full         = (count == DEPTH_C);
  assign bus.empty        = (count == '0);
  assign bus.almost_full  = (count >= AF_C);
  assign bus.almost_empty = (count <= AE_C);
  assign bus.count        = count;
  assign bus.rd_valid     = vld_pipe[1];

  assign wr_acc      = bus.wr_en & ~bus.full;
  assign rd_acc      = bus.rd_en & ~bus.empty;
  assign vld_pipe[0] = rd_acc;

  // storage is deliberately not reset; stale contents are unreachable after reset
  always_ff @(posedge clk) begin
    if (!rst && wr_acc) mem[wr_ptr] <= bus.wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      bus.rd_data   <= '0;
      vld_pipe[1]   <= 1'b0;
      bus.overflow  <= 1'b0;
      bus.underflow <= 1'b0;
    end else begin
      vld_pipe[1] <= vld_pipe[0];
      if (wr_acc) wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
      if (rd_acc) begin
        rd_ptr      <= rd_ptr + ADDR_WIDTH'(1);
        bus.rd_data <= mem[rd_ptr];
      end
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (bus.wr_en && bus.full)  bus.overflow  <= 1'b1;
      if (bus.rd_en && bus.empty) bus.underflow <= 1'b1;
    end
  end
endmodule

// File: tb/tb_sync_fifo_mem.sv
// Randomised + directed bench for sync_fifo_mem: queue-based reference model,
// scoreboard of expected read words drained by an independent monitor.
module tb_sync_fifo_mem;
  localparam int DW = 32, AW = 5, DEPTH = 32, AF = 28, AE = 4;

  logic clk = 1'b0, rst = 1'b0;
  always #5 clk = ~clk;

  sync_fifo_mem_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();
  sync_fifo_mem #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ALMOST_FULL_TH(AF),
                  .ALMOST_EMPTY_TH(AE)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_chk = 0, n_pass = 0;
  logic [DW-1:0] model_q [$];   // FIFO contents as the spec describes them
  logic [DW-1:0] exp_q   [$];   // words the DUT owes on rd_valid
  logic [DW-1:0] m_rd_data = '0;
  logic m_ovf = 1'b0, m_udf = 1'b0, m_rv = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
  endtask

  // monitor: every rd_valid must match the oldest owed word
  always @(posedge clk) begin
    #1;
    if (bus.rd_valid === 1'b1) begin
      if (exp_q.size() == 0) chk("rd_valid_unexpected", 64'(bus.rd_data), 64'hDEAD_0000);
      else chk("rd_data_order", 64'(bus.rd_data), 64'(exp_q.pop_front()));
    end
  end

  task automatic check_state();
    int n;
    n = model_q.size();
    chk("count",        64'(bus.count),        64'(n));
    chk("full",         64'(bus.full),         64'(n == DEPTH));
    chk("empty",        64'(bus.empty),        64'(n == 0));
    chk("almost_full",  64'(bus.almost_full),  64'(n >= AF));
    chk("almost_empty", 64'(bus.almost_empty), 64'(n <= AE));
    chk("overflow",     64'(bus.overflow),     64'(m_ovf));
    chk("underflow",    64'(bus.underflow),    64'(m_udf));
    chk("rd_valid",     64'(bus.rd_valid),     64'(m_rv));
    chk("rd_data_hold", 64'(bus.rd_data),      64'(m_rd_data));
  endtask

  task automatic step(input logic we, input logic [DW-1:0] wd, input logic re);
    bit wa, ra;
    @(negedge clk);
    bus.wr_en = we; bus.wr_data = wd; bus.rd_en = re;
    wa = we && (model_q.size() < DEPTH);
    ra = re && (model_q.size() > 0);
    if (we && !wa) m_ovf = 1'b1;
    if (re && !ra) m_udf = 1'b1;
    if (ra) begin
      m_rd_data = model_q.pop_front();
      exp_q.push_back(m_rd_data);
    end
    if (wa) model_q.push_back(wd);
    m_rv = ra;
    @(posedge clk); #1;
    check_state();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; bus.wr_en = 1'b0; bus.rd_en = 1'b0; bus.wr_data = $urandom;
    model_q.delete(); exp_q.delete();
    m_rd_data = '0; m_ovf = 1'b0; m_udf = 1'b0; m_rv = 1'b0;
    @(posedge clk); #1;
    check_state();
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic fill(input int n);
    for (int i = 0; i < n; i++) step(1'b1, $urandom, 1'b0);
  endtask

  initial begin
    bus.wr_en = 1'b0; bus.rd_en = 1'b0; bus.wr_data = '0;
    // 1: five words in, five out in order
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b1, DW'(32'hA0 + i), 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b0);
    chk("t1_empty", 64'(bus.empty), 64'd1);
    // 2: fill past full, then drain
    do_reset();
    fill(33);
    chk("t2_full_count", 64'(bus.count), 64'd32);
    for (int i = 0; i < 32; i++) step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b0);
    // 3: read while empty
    do_reset();
    step(1'b0, '0, 1'b1);
    chk("t3_underflow", 64'(bus.underflow), 64'd1);
    // 4: steady-state streaming at count 10 across pointer wrap
    do_reset();
    fill(10);
    for (int i = 0; i < 40; i++) step(1'b1, DW'(32'h1000 + i), 1'b1);
    chk("t4_count", 64'(bus.count), 64'd10);
    // 5: simultaneous requests at full and at empty
    do_reset();
    fill(32);
    step(1'b1, DW'(32'hBEEF), 1'b1);
    chk("t5_full_both", 64'(bus.count), 64'd31);
    do_reset();
    step(1'b1, DW'(32'h77), 1'b1);
    chk("t5_empty_both", 64'(bus.count), 64'd1);
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b0);
    // 6: reset mid-stream, then write/read 0x55
    do_reset();
    fill(12);
    step(1'b0, '0, 1'b1);
    do_reset();
    step(1'b1, DW'(32'h55), 1'b0);
    step(1'b0, '0, 1'b1);
    chk("t6_rd_data", 64'(bus.rd_data), 64'h55);
    step(1'b0, '0, 1'b0);
    // random traffic with phases biased towards filling and draining
    for (int ph = 0; ph < 6; ph++) begin
      int pw;
      pw = (ph % 2 == 0) ? 75 : 30;
      for (int i = 0; i < 120; i++)
        step($urandom_range(99) < pw, $urandom, $urandom_range(99) < (100 - pw));
      if (ph == 3) do_reset();
    end
    step(1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b0);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
